delta_decoder: RTL and testbench

DELTA_DECODER -- requirements
Module: delta_decoder

---
 rtl/delta_decoder.sv | 114 +++++++++++
 tb/tb_delta_decoder.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/delta_decoder.sv
// delta_decoder
// Rebuilds a sample stream from 2-bit delta codes. An init load sets the
// accumulator. Each accepted code then moves it by +/-(threshold+1), or
// leaves it unchanged. The result is clamped to [0, 2^W-1] and emitted
// as one recon beat.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   init_data/valid     accumulator load; always accepted, clears counters/err
//   threshold           step size minus one, sampled on acceptance only
//   spike/valid/ready   input delta stream (00 none, 01 up, 11 down, 10 illegal)
//   recon/valid/ready   output reconstructed stream
//   up_count/down_count saturating counts of accepted up/down codes
//   err                 sticky: an illegal code 10 was accepted
//
// Handshake: a beat moves on a rising edge where valid and ready are both 1.
// valid never depends on ready. While valid=1 and ready=0, the data holds
// stable. spike_ready is low in UNINIT and during an init cycle. Otherwise it
// is high whenever the output register is empty or is being drained.
module delta_decoder #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] init_data,
  input  logic         init_valid,
  input  logic [W-1:0] threshold,
  input  logic [1:0]   spike,
  input  logic         spike_valid,
  output logic         spike_ready,
  output logic [W-1:0] recon,
  output logic         recon_valid,
  input  logic         recon_ready,
  output logic [7:0]   up_count,
  output logic [7:0]   down_count,
  output logic         err
);

  typedef enum logic {
    UNINIT = 1'b0,
    RUN    = 1'b1
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [W-1:0]   acc;
  logic           accept;
  logic [W+1:0]   acc_ext;
  logic [W+1:0]   step;
  logic [W+1:0]   raw;
  logic [W-1:0]   next_val;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= UNINIT;
    else     state <= state_next;
  end

  // Next state and handshake
  always_comb begin
    state_next  = state;
    spike_ready = 1'b0;
    if (init_valid) state_next = RUN;
    if (state == RUN && !init_valid)
      spike_ready = !recon_valid || recon_ready;
  end

  assign accept = spike_valid && spike_ready;

  // Compute in W+2 bits. Bit W+1 flags an underflow below zero. Bit W
  // (with bit W+1 clear) flags an overflow above 2^W-1.
  always_comb begin
    acc_ext = {2'b00, acc};
    step    = {2'b00, threshold} + {{(W+1){1'b0}}, 1'b1};
    raw     = acc_ext;
    case (spike)
      2'b01:   raw = acc_ext + step;
      2'b11:   raw = acc_ext - step;
      default: raw = acc_ext;
    endcase
    if (raw[W+1])  next_val = '0;
    else if (raw[W]) next_val = '1;
    else           next_val = raw[W-1:0];
  end

  // Datapath, output register, counters and error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc         <= '0;
      recon       <= '0;
      recon_valid <= 1'b0;
      up_count    <= 8'd0;
      down_count  <= 8'd0;
      err         <= 1'b0;
    end else if (init_valid) begin
      // Init discards any pending beat and produces none of its own.
      acc         <= init_data;
      recon_valid <= 1'b0;
      up_count    <= 8'd0;
      down_count  <= 8'd0;
      err         <= 1'b0;
    end else if (accept) begin
      acc         <= next_val;
      recon       <= next_val;
      recon_valid <= 1'b1;
      if (spike == 2'b01 && up_count != 8'hFF)   up_count   <= up_count + 8'd1;
      if (spike == 2'b11 && down_count != 8'hFF) down_count <= down_count + 8'd1;
      if (spike == 2'b10)                        err        <= 1'b1;
    end else if (recon_ready) begin
      recon_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_delta_decoder.sv
// Self-checking bench for delta_decoder (W=5).
// Driver tasks change inputs 1 time unit after the rising edge. A negedge
// monitor compares every consumed recon beat against the front of exp_q.
// Scenario tasks push the expected beat values and check the status
// outputs inline.
module tb_delta_decoder;
  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] init_data;
  logic         init_valid;
  logic [W-1:0] threshold;
  logic [1:0]   spike;
  logic         spike_valid;
  logic         spike_ready;
  logic [W-1:0] recon;
  logic         recon_valid;
  logic         recon_ready;
  logic [7:0]   up_count;
  logic [7:0]   down_count;
  logic         err;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp;

  delta_decoder #(.W(W)) dut (
    .clk(clk), .rst(rst), .init_data(init_data), .init_valid(init_valid),
    .threshold(threshold), .spike(spike), .spike_valid(spike_valid),
    .spike_ready(spike_ready), .recon(recon), .recon_valid(recon_valid),
    .recon_ready(recon_ready), .up_count(up_count), .down_count(down_count),
    .err(err)
  );

  always #5 clk = ~clk;

  // Scoreboard: each beat consumed on the coming edge must match the queue.
  always @(negedge clk) begin
    if (!rst && recon_valid && recon_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected recon=%0d but no beat expected", recon);
      end else begin
        mon_exp = exp_q.pop_front();
        if (recon !== mon_exp) begin
          errors++;
          $display("FAIL beat_value recon=%0d expected=%0d", recon, mon_exp);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    spike_valid = 1'b0;
    tick();
  endtask

  task automatic do_init(input logic [W-1:0] v);
    spike_valid = 1'b0;
    init_valid  = 1'b1;
    init_data   = v;
    tick();
    init_valid  = 1'b0;
  endtask

  // Offer one code; once the DUT is ready, record the expected beat and
  // let it be accepted on the next edge. spike_valid stays high afterwards.
  task automatic send(input logic [1:0] code, input logic [W-1:0] thr,
                      input logic [W-1:0] exp_v);
    int n;
    spike = code;
    threshold = thr;
    spike_valid = 1'b1;
    n = 0;
    #0;
    while (spike_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (spike_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_timeout spike_ready=%b expected=1 code=%b", spike_ready, code);
    end else begin
      exp_q.push_back(exp_v);
      tick();
    end
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    rst = 1'b1; init_valid = 1'b0; init_data = '0; threshold = '0;
    spike = 2'b01; spike_valid = 1'b1; recon_ready = 1'b1;
    #2;
    checks++; if (recon !== 5'd0) begin errors++; $display("FAIL rst_recon got=%0d expected=0", recon); end
    checks++; if (recon_valid !== 1'b0) begin errors++; $display("FAIL rst_recon_valid got=%b expected=0", recon_valid); end
    checks++; if (spike_ready !== 1'b0) begin errors++; $display("FAIL rst_spike_ready got=%b expected=0", spike_ready); end
    checks++; if (up_count !== 8'd0 || down_count !== 8'd0) begin errors++; $display("FAIL rst_counts got=%0d/%0d expected=0/0", up_count, down_count); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got=%b expected=0", err); end
    repeat (2) tick();
    rst = 1'b0;
    spike_valid = 1'b0;
    tick();
  endtask

  task automatic test_uninit();
    spike = 2'b01; spike_valid = 1'b1; recon_ready = 1'b1;
    repeat (4) begin
      checks++; if (spike_ready !== 1'b0) begin errors++; $display("FAIL uninit_ready got=%b expected=0", spike_ready); end
      checks++; if (recon_valid !== 1'b0) begin errors++; $display("FAIL uninit_valid got=%b expected=0", recon_valid); end
      tick();
    end
    checks++; if (up_count !== 8'd0) begin errors++; $display("FAIL uninit_up got=%0d expected=0", up_count); end
    spike_valid = 1'b0;
  endtask

  task automatic test_basic_stream();
    recon_ready = 1'b1;
    do_init(5'd10);
    send(2'b01, 5'd2, 5'd13);
    checks++; if (recon_valid !== 1'b1) begin errors++; $display("FAIL basic_latency recon_valid=%b expected=1", recon_valid); end
    send(2'b01, 5'd2, 5'd16);
    send(2'b11, 5'd2, 5'd13);
    send(2'b00, 5'd2, 5'd13);
    idle();
    checks++; if (up_count !== 8'd2) begin errors++; $display("FAIL basic_up got=%0d expected=2", up_count); end
    checks++; if (down_count !== 8'd1) begin errors++; $display("FAIL basic_down got=%0d expected=1", down_count); end
    checks++; if (recon_valid !== 1'b0) begin errors++; $display("FAIL basic_drained recon_valid=%b expected=0", recon_valid); end
  endtask

  task automatic test_rails();
    do_init(5'd29); send(2'b01, 5'd3, 5'd31); idle();
    do_init(5'd2);  send(2'b11, 5'd3, 5'd0);  idle();
    do_init(5'd5);  send(2'b01, 5'd31, 5'd31); send(2'b11, 5'd31, 5'd0); idle();
    do_init(5'd31); send(2'b11, 5'd31, 5'd0); idle();
    checks++; if (recon !== 5'd0) begin errors++; $display("FAIL rail_low recon=%0d expected=0", recon); end
  endtask

  task automatic test_backpressure();
    do_init(5'd5);
    recon_ready = 1'b0;
    send(2'b01, 5'd0, 5'd6);
    repeat (3) begin
      checks++; if (spike_ready !== 1'b0) begin errors++; $display("FAIL bp_ready got=%b expected=0", spike_ready); end
      checks++; if (recon !== 5'd6 || recon_valid !== 1'b1) begin errors++; $display("FAIL bp_hold recon=%0d valid=%b expected=6/1", recon, recon_valid); end
      tick();
    end
    recon_ready = 1'b1;
    send(2'b01, 5'd0, 5'd7);
    send(2'b01, 5'd0, 5'd8);
    send(2'b01, 5'd0, 5'd9);
    idle();
  endtask

  task automatic test_err_and_init();
    do_init(5'd9);
    send(2'b01, 5'd1, 5'd11);
    send(2'b10, 5'd1, 5'd11);
    send(2'b01, 5'd0, 5'd12);
    idle();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set got=%b expected=1", err); end
    checks++; if (up_count !== 8'd2) begin errors++; $display("FAIL err_up got=%0d expected=2", up_count); end
    do_init(5'd20);
    checks++; if (err !== 1'b0 || up_count !== 8'd0 || down_count !== 8'd0) begin errors++; $display("FAIL init_clear err=%b up=%0d down=%0d expected=0/0/0", err, up_count, down_count); end
    // Init and spike in the same cycle: init wins, no beat.
    init_valid = 1'b1; init_data = 5'd7; spike = 2'b01; spike_valid = 1'b1; threshold = 5'd1;
    #1;
    checks++; if (spike_ready !== 1'b0) begin errors++; $display("FAIL init_collide_ready got=%b expected=0", spike_ready); end
    tick();
    init_valid = 1'b0; spike_valid = 1'b0;
    checks++; if (recon_valid !== 1'b0 || up_count !== 8'd0) begin errors++; $display("FAIL init_collide_beat valid=%b up=%0d expected=0/0", recon_valid, up_count); end
    send(2'b00, 5'd1, 5'd7);
    idle();
    // Init drops a pending beat.
    recon_ready = 1'b0;
    send(2'b01, 5'd1, 5'd9);
    do_init(5'd3);
    checks++; if (recon_valid !== 1'b0) begin errors++; $display("FAIL init_drop recon_valid=%b expected=0", recon_valid); end
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    recon_ready = 1'b1;
    send(2'b01, 5'd0, 5'd4);
    idle();
  endtask

  task automatic test_counter_saturation();
    do_init(5'd0);
    for (int i = 0; i < 260; i++) send(2'b01, 5'd0, (i + 1 > 31) ? 5'd31 : 5'(i + 1));
    idle();
    checks++; if (up_count !== 8'd255) begin errors++; $display("FAIL up_saturate got=%0d expected=255", up_count); end
    do_init(5'd31);
    for (int i = 0; i < 256; i++) send(2'b11, 5'd0, (31 - i - 1 < 0) ? 5'd0 : 5'(31 - i - 1));
    idle();
    checks++; if (down_count !== 8'd255 || up_count !== 8'd0) begin errors++; $display("FAIL down_saturate down=%0d up=%0d expected=255/0", down_count, up_count); end
  endtask

  task automatic test_random();
    int m_acc, v, m_up, m_down;
    logic m_rv, m_err, exp_ready;
    m_acc = $urandom_range(0, 31);
    do_init(5'(m_acc));
    m_rv = 1'b0; m_up = 0; m_down = 0; m_err = 1'b0;
    for (int i = 0; i < 200; i++) begin
      recon_ready = ($urandom_range(0, 3) != 0);
      spike_valid = $urandom_range(0, 1);
      spike       = 2'($urandom_range(0, 3));
      threshold   = 5'($urandom_range(0, 31));
      #1;
      exp_ready = !m_rv || recon_ready;
      checks++;
      if (spike_ready !== exp_ready) begin errors++; $display("FAIL rand_ready got=%b expected=%b iter=%0d", spike_ready, exp_ready, i); end
      if (spike_valid && exp_ready) begin
        v = m_acc;
        if (spike == 2'b01) v = m_acc + int'(threshold) + 1;
        if (spike == 2'b11) v = m_acc - int'(threshold) - 1;
        if (v < 0) v = 0;
        if (v > 31) v = 31;
        m_acc = v;
        exp_q.push_back(5'(v));
        m_rv = 1'b1;
        if (spike == 2'b01) m_up++;
        if (spike == 2'b11) m_down++;
        if (spike == 2'b10) m_err = 1'b1;
      end else if (recon_ready) begin
        m_rv = 1'b0;
      end
      tick();
    end
    spike_valid = 1'b0; recon_ready = 1'b1;
    tick(); tick();
    checks++; if (up_count !== 8'(m_up) || down_count !== 8'(m_down)) begin errors++; $display("FAIL rand_counts got=%0d/%0d expected=%0d/%0d", up_count, down_count, m_up, m_down); end
    checks++; if (err !== m_err) begin errors++; $display("FAIL rand_err got=%b expected=%b", err, m_err); end
  endtask

  task automatic test_reset_midstream();
    do_init(5'd0);
    recon_ready = 1'b1;
    for (int i = 0; i < 40; i++) send(2'b01, 5'd0, (i + 1 > 31) ? 5'd31 : 5'(i + 1));
    recon_ready = 1'b0;
    spike_valid = 1'b0;
    checks++; if (recon_valid !== 1'b1 || up_count !== 8'd40) begin errors++; $display("FAIL pre_rst valid=%b up=%0d expected=1/40", recon_valid, up_count); end
    #2 rst = 1'b1;
    #1;
    checks++; if (recon !== 5'd0 || recon_valid !== 1'b0) begin errors++; $display("FAIL async_rst_recon recon=%0d valid=%b expected=0/0", recon, recon_valid); end
    checks++; if (up_count !== 8'd0 || down_count !== 8'd0 || err !== 1'b0) begin errors++; $display("FAIL async_rst_status up=%0d down=%0d err=%b expected=0/0/0", up_count, down_count, err); end
    checks++; if (spike_ready !== 1'b0) begin errors++; $display("FAIL async_rst_ready got=%b expected=0", spike_ready); end
    exp_q.delete();
    #3 rst = 1'b0;
    recon_ready = 1'b1; spike = 2'b01; spike_valid = 1'b1;
    #1;
    checks++; if (spike_ready !== 1'b0) begin errors++; $display("FAIL post_rst_ready got=%b expected=0", spike_ready); end
    tick();
    checks++; if (spike_ready !== 1'b0 || recon_valid !== 1'b0) begin errors++; $display("FAIL post_rst_uninit ready=%b valid=%b expected=0/0", spike_ready, recon_valid); end
    spike_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_uninit();
    test_basic_stream();
    test_rails();
    test_backpressure();
    test_err_and_init();
    test_counter_saturation();
    test_random();
    test_reset_midstream();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_beats remaining=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
